// File: rtl/msj_pid_pkg.sv
// Shared types and constants for the msj PID scheduling datapath.
// Contents:
//   DUTY_W            width of a PID duty word
//   CM_*              control-mode encodings used by the PID config registers
//   sched_state_t     scheduler FSM state encoding
package msj_pid_pkg;

    localparam int unsigned DUTY_W = 32;

    localparam logic [1:0] CM_POSITION = 2'b00;
    localparam logic [1:0] CM_VELOCITY = 2'b01;
    localparam logic [1:0] CM_DIRECT   = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        STROBE  = 3'd2,
        WAIT    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } sched_state_t;

endpackage

// File: rtl/msj_rate_divider.sv
// Period counter producing a one-cycle tick every `period` clocks.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   period        clocks per tick; 0 stops the counter (held at 0)
//   tick_c        combinational tick, high while cnt >= period-1
module msj_rate_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] period,
    output logic        tick_c
);

    logic [31:0] cnt;
    logic [31:0] cnt_next;

    // Compare against the live period so a shorter period takes effect at once.
    always_comb begin
        tick_c   = (period != 32'd0) && (cnt >= (period - 32'd1));
        cnt_next = cnt + 32'd1;
        if ((period == 32'd0) || tick_c) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/msj_pid_scheduler.sv
// Time-multiplexes one shared PID controller across NUM_MOTORS motors.
// Each accepted control tick walks the enabled motors in ascending index order:
// select the motor, strobe the PID, wait for its latency, capture its duty.
// Optional feature macro: MSJ_PID_SCHED_ZERO_ON_DISABLE_EN -- when defined,
// disabled motors have their duty cleared at every accepted tick.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   period              clocks per control tick, 0 = stopped
//   enable_mask         per-motor service enable
//   pid_duty            duty returned by the shared PID controller
//   clear_overrun       synchronous clear of overrun_count
//   motor_sel           motor currently steered onto the PID datapath
//   update_controller   one-cycle PID strobe
//   duty_flat           per-motor duty registers, motor i at [32*i +: 32]
//   busy                sweep in progress
//   cycle_done          one-cycle pulse at sweep completion
//   overrun_count       saturating count of ticks dropped while busy
module msj_pid_scheduler
    import msj_pid_pkg::*;
#(
    parameter int unsigned NUM_MOTORS  = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned PID_LATENCY = 2,
    parameter int unsigned SETTLE      = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  period,
    input  logic [NUM_MOTORS-1:0]        enable_mask,
    input  logic signed [31:0]           pid_duty,
    input  logic                         clear_overrun,
    output logic [IDX_W-1:0]             motor_sel,
    output logic                         update_controller,
    output logic [NUM_MOTORS*DUTY_W-1:0] duty_flat,
    output logic                         busy,
    output logic                         cycle_done,
    output logic [15:0]                  overrun_count
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_SELECT  = SELECT;
    localparam logic [2:0] ST_STROBE  = STROBE;
    localparam logic [2:0] ST_WAIT    = WAIT;
    localparam logic [2:0] ST_CAPTURE = CAPTURE;
    localparam logic [2:0] ST_DONE    = DONE;

    localparam int unsigned WCNT_W = $clog2(SETTLE + PID_LATENCY + 1);

    logic              tick;
    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [IDX_W-1:0]  sel_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic [15:0]       overrun_next;
    logic              capture;
    logic              accept;
    logic [IDX_W:0]    first_hit;
    logic [IDX_W:0]    next_hit;

    msj_rate_divider u_rate_divider (
        .clock  (clock),
        .reset  (reset),
        .period (period),
        .tick_c (tick)
    );

    // Lowest enabled index >= start; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] find_enabled(input logic [NUM_MOTORS-1:0] mask,
                                                    input int start);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = int'(NUM_MOTORS) - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    // Next-state and datapath-next logic.
    always_comb begin
        state_next   = state;
        sel_next     = motor_sel;
        wcnt_next    = wcnt;
        capture      = 1'b0;
        accept       = 1'b0;
        overrun_next = overrun_count;
        first_hit    = find_enabled(enable_mask, 0);
        next_hit     = find_enabled(enable_mask, int'(motor_sel) + 1);

        case (state)
            ST_IDLE: begin
                if (tick) begin
                    accept    = 1'b1;
                    wcnt_next = '0;
                    if (first_hit[IDX_W]) begin
                        sel_next   = first_hit[IDX_W-1:0];
                        state_next = ST_SELECT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_SELECT: begin
                if (wcnt == WCNT_W'(SETTLE - 1)) begin
                    wcnt_next  = '0;
                    state_next = ST_STROBE;
                end else begin
                    wcnt_next = wcnt + WCNT_W'(1);
                end
            end
            ST_STROBE: begin
                wcnt_next  = '0;
                state_next = (PID_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                if (wcnt == WCNT_W'(PID_LATENCY - 2)) begin
                    wcnt_next  = '0;
                    state_next = ST_CAPTURE;
                end else begin
                    wcnt_next = wcnt + WCNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                if (next_hit[IDX_W]) begin
                    sel_next   = next_hit[IDX_W-1:0];
                    state_next = ST_SELECT;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A tick outside IDLE (including DONE) is dropped and counted.
        if (clear_overrun) begin
            overrun_next = '0;
        end else if (tick && (state != ST_IDLE) && (overrun_count != 16'hFFFF)) begin
            overrun_next = overrun_count + 16'd1;
        end
    end

    // State, control outputs and counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            motor_sel         <= '0;
            wcnt              <= '0;
            update_controller <= 1'b0;
            busy              <= 1'b0;
            cycle_done        <= 1'b0;
            overrun_count     <= '0;
        end else begin
            state             <= state_next;
            motor_sel         <= sel_next;
            wcnt              <= wcnt_next;
            update_controller <= (state_next == ST_STROBE);
            busy              <= (state_next != ST_IDLE);
            cycle_done        <= (state_next == ST_DONE);
            overrun_count     <= overrun_next;
        end
    end

    // Per-motor duty registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            duty_flat <= '0;
        end else begin
`ifdef MSJ_PID_SCHED_ZERO_ON_DISABLE_EN
            if (accept) begin
                for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                    if (!enable_mask[i]) begin
                        duty_flat[DUTY_W*i +: DUTY_W] <= '0;
                    end
                end
            end
`else
            // Disabled motors simply keep their last captured duty.
            if (accept && 1'b0) begin
                duty_flat <= '0;
            end
`endif
            if (capture) begin
                duty_flat[DUTY_W*int'(motor_sel) +: DUTY_W] <= pid_duty;
            end
        end
    end

endmodule
